// File: rtl/uart_echo_buffer.sv
// Receive FIFO between the UART receiver and transmitter, drained by a transmit FSM
// that echoes either byte-by-byte (stream) or in whole frames of FRAME_LEN bytes.
module uart_echo_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned FRAME_LEN  = 4
) (
    input  logic                    CLK100MHZ,
    input  logic                    CPU_RESETN,
    input  logic                    mode,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_ready,
    input  logic                    tx_busy,
    input  logic                    clear_overflow,
    output logic                    tx_start,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           frame_left;
    logic                    mode_q;
    logic                    eff_mode;
    logic                    load;
    logic                    pop;
    logic                    push;
    logic                    full;
    logic                    drop;

    // While a frame is in progress the latched mode governs; otherwise the live input does.
    always_comb begin
        eff_mode = (frame_left != '0) ? mode_q : mode;
        if (!eff_mode || frame_left != '0) begin
            load = (fifo_count != '0);
        end else begin
            load = (fifo_count >= CW'(FRAME_LEN));
        end
    end

    assign full = (fifo_count == CW'(DEPTH));
    assign push = rx_ready && (!full || pop);
    assign drop = rx_ready && full && !pop;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (load) state_next = START;
            START:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_start = (state == START);
        pop      = (state == START);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // mode_q only follows mode between frames, so a started frame always runs to completion.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            tx_data    <= '0;
            frame_left <= '0;
            mode_q     <= 1'b0;
        end else if (state == IDLE) begin
            if (frame_left == '0) mode_q <= mode;
            if (load) begin
                tx_data <= mem[rd_ptr];
                if (eff_mode && frame_left == '0) frame_left <= CW'(FRAME_LEN);
            end
        end else if (state == START && mode_q && frame_left != '0) begin
            frame_left <= frame_left - 1'b1;
        end
    end

endmodule
